// File: rtl/tree_pkg.sv
// ============================================================================
// tree_pkg : shared types and depth-3 default tables for the tree classifier
// Rev 1.0
// ============================================================================
`default_nettype none

package tree_pkg;

  localparam int TREE_DATA_WIDTH  = 8;
  localparam int TREE_DEPTH_DEF   = 3;
  localparam int TREE_CLASS_WIDTH = 3;
  localparam int NUM_NODES        = (1 << TREE_DEPTH_DEF) - 1;
  localparam int NUM_LEAVES       = 1 << TREE_DEPTH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_WALK    = 2'd2,
    ST_EMIT    = 2'd3
  } state_e;

  // Heap-ordered node thresholds: children of node n are 2n+1 (below) and 2n+2.
  localparam logic [TREE_DATA_WIDTH-1:0] DEFAULT_THRESH [NUM_NODES] = '{
    8'd128, 8'd64, 8'd192, 8'd32, 8'd96, 8'd160, 8'd224
  };

  localparam logic [TREE_CLASS_WIDTH-1:0] LEAF_CLASS [NUM_LEAVES] = '{
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7
  };

endpackage

`default_nettype wire

// File: rtl/tree_classifier_fsm_if.sv
// ============================================================================
// tree_classifier_fsm_if : sample/result/config bundle for the tree classifier
// Rev 1.0
// ============================================================================
`default_nettype none

interface tree_classifier_fsm_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int TREE_DEPTH  = 3,
  parameter int CLASS_WIDTH = 3
);
  logic [DATA_WIDTH-1:0]  data_in;
  logic                   data_ready;
  logic                   data_processed;
  logic [CLASS_WIDTH-1:0] class_out;
  logic                   class_valid;
  logic                   busy;
  logic                   cfg_we;
  logic [TREE_DEPTH-1:0]  cfg_addr;
  logic [DATA_WIDTH-1:0]  cfg_data;

  modport master (
    output data_in, data_ready, cfg_we, cfg_addr, cfg_data,
    input  data_processed, class_out, class_valid, busy
  );

  modport slave (
    input  data_in, data_ready, cfg_we, cfg_addr, cfg_data,
    output data_processed, class_out, class_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/tree_classifier_fsm_node_step.sv
// ============================================================================
// tree_node_step : one decision-tree hop, node -> 2*node+1+(feature>=thresh)
// Rev 1.0
// ============================================================================
`default_nettype none

module tree_node_step #(
  parameter int DATA_WIDTH = 8,
  parameter int TREE_DEPTH = 3
) (
  input  logic [TREE_DEPTH:0]   node_i,
  input  logic [DATA_WIDTH-1:0] feature_i,
  input  logic [DATA_WIDTH-1:0] thresh_i,
  output logic [TREE_DEPTH:0]   node_o
);
  logic go_right;

  assign go_right = (feature_i >= thresh_i);
  assign node_o   = (node_i << 1) + (TREE_DEPTH+1)'(1) + (TREE_DEPTH+1)'(go_right);
endmodule

`default_nettype wire

// File: rtl/tree_classifier_fsm.sv
// ============================================================================
// tree_classifier_fsm : captures a feature word, walks a binary decision tree
// one node per clock, emits a class label. Macro THRESH_LOAD_EN adds a
// writable threshold register file. Rev 1.0
// ============================================================================
`default_nettype none

module tree_classifier_fsm
  import tree_pkg::*;
#(
  parameter int DATA_WIDTH  = TREE_DATA_WIDTH,
  parameter int TREE_DEPTH  = TREE_DEPTH_DEF,
  parameter int CLASS_WIDTH = TREE_CLASS_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tree_classifier_fsm_if.slave bus_if
);
  localparam int                  STEP_W    = $clog2(TREE_DEPTH + 1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(TREE_DEPTH - 1);
  localparam logic [TREE_DEPTH:0] LEAF_BASE = (TREE_DEPTH+1)'((1 << TREE_DEPTH) - 1);

  state_e                 state_q;
  logic [DATA_WIDTH-1:0]  feature_q;
  logic [TREE_DEPTH:0]    node_q;
  logic [TREE_DEPTH:0]    node_d;
  logic [STEP_W-1:0]      step_q;
  logic [CLASS_WIDTH-1:0] class_out_q;
  logic                   class_valid_q;
  logic [DATA_WIDTH-1:0]  thresh_sel;
  logic [TREE_DEPTH:0]    leaf_idx;
  logic                   node_internal;

  // Only nodes 0..2^D-2 carry a threshold; leaf indices select nothing.
  assign node_internal = !node_q[TREE_DEPTH] && (node_q[TREE_DEPTH-1:0] != '1);

`ifdef THRESH_LOAD_EN
  logic [DATA_WIDTH-1:0] thresh_q [NUM_NODES];
  logic                  cfg_wr_ok;

  // Top address is one past the last node, so an all-ones address is dropped.
  assign cfg_wr_ok = (state_q == ST_IDLE) && bus_if.cfg_we && (bus_if.cfg_addr != '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        thresh_q[i] <= DEFAULT_THRESH[i];
      end
    end else if (cfg_wr_ok) begin
      thresh_q[bus_if.cfg_addr] <= bus_if.cfg_data;
    end
  end

  always_comb begin
    thresh_sel = '0;
    if (node_internal) thresh_sel = thresh_q[node_q[TREE_DEPTH-1:0]];
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus_if.cfg_we, bus_if.cfg_addr, bus_if.cfg_data};

  always_comb begin
    thresh_sel = '0;
    if (node_internal) thresh_sel = DEFAULT_THRESH[node_q[TREE_DEPTH-1:0]];
  end
`endif

  tree_node_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .TREE_DEPTH (TREE_DEPTH)
  ) u_node_step (
    .node_i    (node_q),
    .feature_i (feature_q),
    .thresh_i  (thresh_sel),
    .node_o    (node_d)
  );

  assign leaf_idx = node_q - LEAF_BASE;

  logic unused_leaf;
  assign unused_leaf = leaf_idx[TREE_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      feature_q     <= '0;
      node_q        <= '0;
      step_q        <= '0;
      class_out_q   <= '0;
      class_valid_q <= 1'b0;
    end else begin
      class_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus_if.data_ready) state_q <= ST_CAPTURE;
        end
        // The buffer presents the word one edge after its ready pulse.
        ST_CAPTURE: begin
          feature_q <= bus_if.data_in;
          node_q    <= '0;
          step_q    <= '0;
          state_q   <= ST_WALK;
        end
        ST_WALK: begin
          node_q <= node_d;
          step_q <= step_q + STEP_W'(1);
          if (step_q == STEP_LAST) state_q <= ST_EMIT;
        end
        ST_EMIT: begin
          class_out_q   <= LEAF_CLASS[leaf_idx[TREE_DEPTH-1:0]];
          class_valid_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_if.data_processed = (state_q == ST_IDLE);
  assign bus_if.busy           = (state_q != ST_IDLE);
  assign bus_if.class_out      = class_out_q;
  assign bus_if.class_valid    = class_valid_q;
endmodule

`default_nettype wire

// File: tb/tb_tree_classifier_fsm.sv
// ============================================================================
// tb_tree_classifier_fsm : directed self-checking bench for tree_classifier_fsm
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tree_classifier_fsm;
  localparam int DW = 8;
  localparam int TD = 3;
  localparam int CW = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  tree_classifier_fsm_if #(.DATA_WIDTH(DW), .TREE_DEPTH(TD), .CLASS_WIDTH(CW)) bus_if ();

  tree_classifier_fsm #(
    .DATA_WIDTH  (DW),
    .TREE_DEPTH  (TD),
    .CLASS_WIDTH (CW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: clean; mode 1: data_ready pulses during WALK; mode 2: cfg write during WALK
  task automatic run_sample(input string tag, input logic [7:0] feat,
                            input logic [2:0] exp_cls, input int mode);
    int          lat;
    logic [2:0]  prev;
    prev = bus_if.class_out;
    lat  = 0;
    @(negedge clk);
    bus_if.data_ready = 1'b1;
    @(negedge clk);
    bus_if.data_ready = 1'b0;
    bus_if.data_in    = feat;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (bus_if.class_valid === 1'b1) begin
        lat = i;
        chk({tag, " dp at valid"}, bus_if.data_processed, 1);
      end else if (i < 5) begin
        chk({tag, " dp low"},  bus_if.data_processed, 0);
        chk({tag, " busy"},    bus_if.busy, 1);
        chk({tag, " hold"},    bus_if.class_out, prev);
      end
      bus_if.data_ready = (mode == 1) && (i == 1 || i == 2);
      if (mode == 1) bus_if.data_in = 8'hFF;
      bus_if.cfg_we   = (mode == 2) && (i == 1);
      bus_if.cfg_addr = '0;
      bus_if.cfg_data = 8'hFF;
    end
    bus_if.data_ready = 1'b0;
    bus_if.cfg_we     = 1'b0;
    chk({tag, " latency"}, lat, 5);
    chk({tag, " class"},   bus_if.class_out, exp_cls);
    @(negedge clk);
    chk({tag, " pulse"},   bus_if.class_valid, 0);
  endtask

  initial begin
    bus_if.data_in    = '0;
    bus_if.data_ready = 1'b0;
    bus_if.cfg_we     = 1'b0;
    bus_if.cfg_addr   = '0;
    bus_if.cfg_data   = '0;
    rst_n             = 1'b0;
    #12;
    chk("rst class_out", bus_if.class_out, 0);
    chk("rst valid",     bus_if.class_valid, 0);
    chk("rst busy",      bus_if.busy, 0);
    chk("rst dp",        bus_if.data_processed, 1);
    @(negedge clk);
    rst_n = 1'b1;

    run_sample("f00", 8'h00, 3'd0, 0);
    run_sample("fFF", 8'hFF, 3'd7, 0);
    run_sample("f80", 8'h80, 3'd4, 0);
    run_sample("f7F", 8'h7F, 3'd3, 0);
    run_sample("f40", 8'h40, 3'd2, 0);
    run_sample("f3F", 8'h3F, 3'd1, 0);

    run_sample("noise", 8'h00, 3'd0, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("noise no 2nd valid", bus_if.class_valid, 0);
      chk("noise idle",         bus_if.data_processed, 1);
    end

    // Abort a walk: class_out is nonzero beforehand so the clear is visible.
    run_sample("pre", 8'h7F, 3'd3, 0);
    @(negedge clk);
    bus_if.data_ready = 1'b1;
    @(negedge clk);
    bus_if.data_ready = 1'b0;
    bus_if.data_in    = 8'h80;
    @(negedge clk);
    @(negedge clk);
    chk("abort busy before", bus_if.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort class_out", bus_if.class_out, 0);
    chk("abort valid",     bus_if.class_valid, 0);
    chk("abort busy",      bus_if.busy, 0);
    chk("abort dp",        bus_if.data_processed, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      chk("abort no valid", bus_if.class_valid, 0);
    end
    run_sample("post", 8'hFF, 3'd7, 0);

`ifdef THRESH_LOAD_EN
    @(negedge clk);
    bus_if.cfg_we   = 1'b1;
    bus_if.cfg_addr = 3'd0;
    bus_if.cfg_data = 8'h10;
    @(negedge clk);
    bus_if.cfg_we   = 1'b0;
    run_sample("cfg n0", 8'h20, 3'd4, 2);
    run_sample("cfg drop", 8'h20, 3'd4, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/tree_classifier_fsm.md
Name: tree_classifier_fsm

Overview:
- Downstream consumer of the serial-to-parallel sensor input buffer.
- Captures each completed DATA_WIDTH-bit feature word and walks a fixed-depth binary decision tree, one node per clock.
- Emits a class label with a one-cycle valid pulse.
- Drives the buffer's data_processed input as a level "ready for next sample" request.

Parameters:
DATA_WIDTH, 8, width of feature word and of each node threshold
TREE_DEPTH, 3, comparisons per classification; 2^TREE_DEPTH-1 internal nodes, 2^TREE_DEPTH leaves
CLASS_WIDTH, 3, width of class label

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data_in  in  DATA_WIDTH  feature word from input buffer (its data_output)
data_ready  in  1  one-cycle pulse from input buffer; data_in is valid the cycle after the pulse
data_processed  out  1  high while IDLE = request next sample; wired to buffer's data_processed
class_out  out  CLASS_WIDTH  last classification result, held until next result
class_valid  out  1  one-cycle pulse, class_out updated in same cycle
busy  out  1  high in every state except IDLE
cfg_we  in  1  threshold write strobe (used only with THRESH_LOAD_EN)
cfg_addr  in  TREE_DEPTH  node index 0..2^TREE_DEPTH-2
cfg_data  in  DATA_WIDTH  threshold value

Behaviour:
- Reset (rst_n low, async):
  - State is IDLE; class_out=0, class_valid=0, busy=0, data_processed=1 immediately.
  - Internal feature, node and step registers are cleared.
- States are IDLE, CAPTURE, WALK and EMIT.
- IDLE:
  - data_processed=1.
  - data_ready=1 sampled at edge → CAPTURE.
- CAPTURE:
  - Latch data_in into the feature register; node=0; step=0 → WALK.
  - This is required because the buffer updates data_output on the edge after data_ready.
- WALK:
  - Each cycle: node <= 2*node+1+(feature >= thresh[node]), unsigned compare; step++.
  - After TREE_DEPTH steps → EMIT.
  - Node register is TREE_DEPTH+1 bits wide; no overflow is possible.
- EMIT:
  - leaf = node-(2^TREE_DEPTH-1).
  - class_out <= LEAF_CLASS[leaf]; class_valid=1 for exactly this cycle → IDLE.
- Latency: data_ready sampled at edge E gives class_valid high in the cycle after edge E+TREE_DEPTH+2, i.e. 5 cycles after the data_ready pulse for TREE_DEPTH=3. Back-to-back throughput is limited by the buffer refill.
- data_processed and busy are combinational decodes of the state register; class_out and class_valid are registered.
- data_ready outside IDLE is ignored; no queuing, and class_out is not disturbed.
- class_valid never asserts twice for one sample.
- Reset asserted mid-WALK or EMIT aborts the walk: no class_valid, class_out returns to 0.

Optional Feature:
- Macro: THRESH_LOAD_EN.
- Defined:
  - Thresholds are held in a register file initialised from the package defaults on reset.
  - cfg_we=1 in IDLE writes cfg_data to thresh[cfg_addr].
  - Writes in any other state, or with cfg_addr > 2^TREE_DEPTH-2, are dropped.
  - A write and a data_ready in the same IDLE cycle: the write lands first; the new threshold is used by the walk.
- Not defined:
  - Thresholds are package constants; cfg_* ports are present but ignored.
  - No threshold registers are inferred.

Decomposition:
- Package tree_pkg holds:
  - state enum (IDLE, CAPTURE, WALK, EMIT);
  - default thresholds for depth 3: node0..6 = 128, 64, 192, 32, 96, 160, 224;
  - LEAF_CLASS table, default leaf i → class i.
- Sub-module tree_node_step (combinational): takes current node, feature and threshold; returns next node. Reused by any later pipelined/unrolled variant.

Test Plan:
- Reset mid-WALK: feature 0x80, assert rst_n low on the second WALK cycle → outputs return to reset values immediately, no class_valid; the next sample 0xFF still yields class 7.
- data_ready with data_in 0x00 on the next cycle → class_valid high 5 cycles later, class_out=0; data_processed low throughout, high again the following cycle.
- Features 0xFF, 0x80, 0x7F → class 7, 4, 3 respectively (paths 0→2→6→14; 0→2→5→11; 0→1→4→10).
- Boundary equals threshold: feature 0x40 → path 0→1→4→9, class 2; feature 0x3F → path 0→1→3→8, class 1.
- data_ready pulses during WALK → ignored, exactly one class_valid per accepted sample, class_out unchanged until EMIT.
- With THRESH_LOAD_EN: write node0=0x10 in IDLE, then feature 0x20 → path 0→2→5→11, class 4. A write issued during WALK is dropped, so node0 still reads 0x10 on the next sample.
